// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register with sub-word load extraction, result select, int/FP write routing; retire counter under `WB_INSTRET_EN`.
// Latency: one cycle, M-side inputs appear on the registered W outputs after the next rising edge.
// Backpressure: StallW holds every output bit-exact and drops M inputs; FlushW loads a bubble and beats StallW.
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            isFPUM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      LoadTypeM,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] ReadDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [4:0]      RdM,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic            FRegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic [63:0]     InstRetW
);

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            fRegWrite;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
    } wbReg_t;

    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] resultM;
    wbReg_t          wbNext;
    wbReg_t          wbQ;

    // Byte lane from addr[1:0], half lane from addr[1]; addr[0] is ignored for halves.
    always_comb begin
        case (ALU_ResultM[1:0])
            2'd0:    loadByte = ReadDataM[7:0];
            2'd1:    loadByte = ReadDataM[15:8];
            2'd2:    loadByte = ReadDataM[23:16];
            default: loadByte = ReadDataM[31:24];
        endcase
        loadHalf = ALU_ResultM[1] ? ReadDataM[31:16] : ReadDataM[15:0];
    end

    // FP loads are always full-word (flw); reserved funct3 codes fall back to LW.
    always_comb begin
        loadData = ReadDataM;
        if (!isFPUM) begin
            case (LoadTypeM)
                3'b000:  loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
                3'b001:  loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
                3'b100:  loadData = {{(XLEN-8){1'b0}}, loadByte};
                3'b101:  loadData = {{(XLEN-16){1'b0}}, loadHalf};
                default: loadData = ReadDataM;
            endcase
        end
    end

    always_comb begin
        case (ResultSrcM)
            2'b01:   resultM = loadData;
            2'b10:   resultM = PCPlus4M;
            default: resultM = ALU_ResultM;
        endcase
    end

    always_comb begin
        wbNext           = '0;
        wbNext.valid     = ValidM;
        wbNext.regWrite  = RegWriteM & ValidM & ~isFPUM & (RdM != 5'd0);
        wbNext.fRegWrite = RegWriteM & ValidM & isFPUM;
        wbNext.rd        = RdM;
        wbNext.result    = resultM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbQ <= '0;
        end else if (FlushW) begin
            wbQ <= '0;
        end else if (!StallW) begin
            wbQ <= wbNext;
        end
    end

    assign ValidW     = wbQ.valid;
    assign RegWriteW  = wbQ.regWrite;
    assign FRegWriteW = wbQ.fRegWrite;
    assign RdW        = wbQ.rd;
    assign ResultW    = wbQ.result;

`ifdef WB_INSTRET_EN
    logic [63:0] instRetQ;

    // Counts only edges that actually load a real instruction into W.
    always_ff @(posedge clk) begin
        if (rst) begin
            instRetQ <= '0;
        end else if (!FlushW && !StallW && ValidM) begin
            instRetQ <= instRetQ + 64'd1;
        end
    end

    assign InstRetW = instRetQ;
`else
    assign InstRetW = 64'h0;
`endif

endmodule
